// File: rtl/button_debouncer.sv
// Push-button conditioner: per-button 2-FF synchronizer, debounce counter and FSM.
// Emits one registered strobe per accepted press plus the debounced level.
module button_debouncer #(
    parameter int unsigned NB_BUTTONS      = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned NB_COUNTER      = 20
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [NB_BUTTONS-1:0] i_buttons,
    output logic [NB_BUTTONS-1:0] o_pulses,
    output logic [NB_BUTTONS-1:0] o_levels
);

    localparam logic [NB_COUNTER-1:0] LP_COUNT_LAST = NB_COUNTER'(DEBOUNCE_CYCLES - 1);
    localparam logic [NB_COUNTER-1:0] LP_COUNT_ONE  = NB_COUNTER'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HIGH = 2'd1,
        PRESSED   = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    logic [NB_BUTTONS-1:0] r_meta;
    logic [NB_BUTTONS-1:0] r_sync;
    logic [NB_BUTTONS-1:0] r_level;
    logic [NB_BUTTONS-1:0] r_pulse;

    // Two-flop synchronizer; only r_sync feeds the debounce logic
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_buttons;
            r_sync <= r_meta;
        end
    end

    for (genvar g = 0; g < NB_BUTTONS; g++) begin : g_button
        state_t                r_state;
        state_t                w_state_next;
        logic [NB_COUNTER-1:0] r_count;
        logic [NB_COUNTER-1:0] w_count_next;
        logic                  w_level_next;
        logic                  w_pulse_next;

        always_ff @(posedge i_clock) begin
            if (i_reset) begin
                r_state    <= IDLE;
                r_count    <= '0;
                r_level[g] <= 1'b0;
                r_pulse[g] <= 1'b0;
            end else begin
                r_state    <= w_state_next;
                r_count    <= w_count_next;
                r_level[g] <= w_level_next;
                r_pulse[g] <= w_pulse_next;
            end
        end

        always_comb begin
            w_state_next = r_state;
            w_count_next = r_count;
            w_level_next = r_level[g];
            w_pulse_next = 1'b0;
            case (r_state)
                IDLE: begin
                    w_level_next = 1'b0;
                    if (r_sync[g]) begin
                        w_state_next = WAIT_HIGH;
                        w_count_next = LP_COUNT_ONE;
                    end else begin
                        w_count_next = '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!r_sync[g]) begin
                        w_state_next = IDLE;
                        w_count_next = '0;
                    end else if (r_count == LP_COUNT_LAST) begin
                        w_state_next = PRESSED;
                        w_level_next = 1'b1;
                        w_pulse_next = 1'b1;
                        w_count_next = '0;
                    end else begin
                        w_count_next = r_count + LP_COUNT_ONE;
                    end
                end
                PRESSED: begin
                    w_level_next = 1'b1;
                    if (!r_sync[g]) begin
                        w_state_next = WAIT_LOW;
                        w_count_next = LP_COUNT_ONE;
                    end
                end
                WAIT_LOW: begin
                    if (r_sync[g]) begin
                        w_state_next = PRESSED;
                        w_count_next = '0;
                    end else if (r_count == LP_COUNT_LAST) begin
                        w_state_next = IDLE;
                        w_level_next = 1'b0;
                        w_count_next = '0;
                    end else begin
                        w_count_next = r_count + LP_COUNT_ONE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_count_next = '0;
                    w_level_next = 1'b0;
                end
            endcase
        end
    end

    // Output stage: aligns the strobe to DEBOUNCE_CYCLES+2 edges after the first high sample
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_pulses <= '0;
            o_levels <= '0;
        end else begin
            o_pulses <= r_pulse;
            o_levels <= r_level;
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4: press, bounce,
// glitch, simultaneous press/release and reset in the middle of a press.
module tb_button_debouncer;

    localparam int unsigned NB = 3;

    logic          i_clock = 1'b0;
    logic          i_reset;
    logic [NB-1:0] i_buttons;
    logic [NB-1:0] o_pulses;
    logic [NB-1:0] o_levels;

    int n_cmp = 0;
    int n_err = 0;

    button_debouncer #(
        .NB_BUTTONS     (NB),
        .DEBOUNCE_CYCLES(4),
        .NB_COUNTER     (3)
    ) dut (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_buttons(i_buttons),
        .o_pulses (o_pulses),
        .o_levels (o_levels)
    );

    always #5 i_clock = ~i_clock;

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic do_reset();
        i_buttons = '0;
        i_reset   = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_buttons = '0;
        i_reset   = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            n_cmp++;
            if (o_pulses !== 3'b000 || o_levels !== 3'b000) begin
                n_err++;
                $display("FAIL reset_hold cyc=%0d pulses=%b levels=%b want 000/000", n, o_pulses, o_levels);
            end
        end
        i_reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            n_cmp++;
            if (o_pulses !== 3'b000 || o_levels !== 3'b000) begin
                n_err++;
                $display("FAIL reset_after cyc=%0d pulses=%b levels=%b want 000/000", n, o_pulses, o_levels);
            end
        end
    endtask

    task automatic test_clean_press();
        do_reset();
        i_buttons = 3'b001;
        for (int n = 1; n <= 20; n++) begin
            tick();
            n_cmp++;
            if (o_pulses !== ((n == 7) ? 3'b001 : 3'b000)) begin
                n_err++;
                $display("FAIL clean_pulse n=%0d got=%b want=%b", n, o_pulses, (n == 7) ? 3'b001 : 3'b000);
            end
            n_cmp++;
            if (o_levels !== ((n >= 7) ? 3'b001 : 3'b000)) begin
                n_err++;
                $display("FAIL clean_level n=%0d got=%b want=%b", n, o_levels, (n >= 7) ? 3'b001 : 3'b000);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] seq;
        do_reset();
        seq = 5'b10101;
        for (int s = 0; s < 4; s++) begin
            i_buttons = {1'b0, seq[s], 1'b0};
            tick();
            n_cmp++;
            if (o_pulses !== 3'b000) begin
                n_err++;
                $display("FAIL bounce_early s=%0d got=%b want=000", s, o_pulses);
            end
        end
        i_buttons = 3'b010;
        for (int n = 1; n <= 20; n++) begin
            tick();
            n_cmp++;
            if (o_pulses !== ((n == 7) ? 3'b010 : 3'b000)) begin
                n_err++;
                $display("FAIL bounce_pulse n=%0d got=%b want=%b", n, o_pulses, (n == 7) ? 3'b010 : 3'b000);
            end
        end
        n_cmp++;
        if (o_levels !== 3'b010) begin
            n_err++;
            $display("FAIL bounce_level got=%b want=010", o_levels);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        i_buttons = 3'b100;
        tick();
        tick();
        tick();
        i_buttons = 3'b000;
        for (int n = 1; n <= 15; n++) begin
            tick();
            n_cmp++;
            if (o_pulses !== 3'b000 || o_levels !== 3'b000) begin
                n_err++;
                $display("FAIL glitch n=%0d pulses=%b levels=%b want 000/000", n, o_pulses, o_levels);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        i_buttons = 3'b111;
        for (int n = 1; n <= 20; n++) begin
            tick();
            n_cmp++;
            if (o_pulses !== ((n == 7) ? 3'b111 : 3'b000) || o_levels !== ((n >= 7) ? 3'b111 : 3'b000)) begin
                n_err++;
                $display("FAIL simul_press n=%0d pulses=%b levels=%b", n, o_pulses, o_levels);
            end
        end
        i_buttons = 3'b000;
        for (int n = 1; n <= 12; n++) begin
            tick();
            n_cmp++;
            if (o_pulses !== 3'b000 || o_levels !== ((n >= 7) ? 3'b000 : 3'b111)) begin
                n_err++;
                $display("FAIL simul_release n=%0d pulses=%b levels=%b want 000/%b", n, o_pulses, o_levels,
                         (n >= 7) ? 3'b000 : 3'b111);
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses_seen;
        pulses_seen = 0;
        do_reset();
        i_buttons = 3'b001;
        for (int n = 0; n < 3; n++) begin
            tick();
            n_cmp++;
            if (o_pulses !== 3'b000) begin
                n_err++;
                $display("FAIL mid_pre n=%0d got=%b want=000", n, o_pulses);
            end
        end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        n_cmp++;
        if (o_pulses !== 3'b000 || o_levels !== 3'b000) begin
            n_err++;
            $display("FAIL mid_reset pulses=%b levels=%b want 000/000", o_pulses, o_levels);
        end
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (o_pulses[0] === 1'b1) pulses_seen++;
            n_cmp++;
            if (o_pulses !== ((n == 7) ? 3'b001 : 3'b000)) begin
                n_err++;
                $display("FAIL mid_post n=%0d got=%b want=%b", n, o_pulses, (n == 7) ? 3'b001 : 3'b000);
            end
        end
        n_cmp++;
        if (pulses_seen != 1) begin
            n_err++;
            $display("FAIL mid_count got=%0d want=1", pulses_seen);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout sim time=%0t limit=100000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        i_reset   = 1'b1;
        i_buttons = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
